// File: rtl/spi_controller.sv
// Mode-0 SPI controller: each accepted command becomes one 16-bit {rw, addr[6:0], data[7:0]} frame, MSB first.
// Accept-to-done is 34*CLK_DIV+1 cycles; cmd_ready_o stays low while a frame is in flight.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [6:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       sclk_o,
    output logic       ncs_o,
    output logic       copi_o,
    input  logic       cipo_i
);

    if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_controller: CLK_DIV must be within 3..255");
    end

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        copi_q, copi_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        half_end;

    assign half_end = (half_cnt_q == 8'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            half_cnt_q <= HALF_LAST;
            bit_cnt_q  <= 5'd0;
            shreg_q    <= 16'h0000;
            cap_q      <= 8'h00;
            rd_data_q  <= 8'h00;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            copi_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            cap_q      <= cap_d;
            rd_data_q  <= rd_data_d;
            sclk_q     <= sclk_d;
            ncs_q      <= ncs_d;
            copi_q     <= copi_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_end ? HALF_LAST : half_cnt_q - 8'd1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        cap_d      = cap_q;
        rd_data_d  = rd_data_q;
        sclk_d     = sclk_q;
        ncs_d      = ncs_q;
        copi_d     = copi_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                half_cnt_d = HALF_LAST;
                if (cmd_valid_i && ready_q) begin
                    state_d   = SHIFT;
                    shreg_d   = {cmd_write_i, cmd_addr_i, cmd_data_i};
                    bit_cnt_d = 5'd0;
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    copi_d    = cmd_write_i;
                    ready_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: next bit goes out while sclk is low, giving a full half-period of setup.
                        sclk_d    = 1'b0;
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        copi_d    = shreg_q[14];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q[3]) begin
                            cap_d = {cap_q[6:0], cipo_i};
                        end
                        if (bit_cnt_q == 5'd15) begin
                            state_d = HOLD;
                            copi_d  = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    state_d = GAP;
                    ncs_d   = 1'b1;
                end
            end
            GAP: begin
                if (half_end) begin
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    done_d    = 1'b1;
                    rd_data_d = cap_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign rd_data_o   = rd_data_q;
    assign sclk_o      = sclk_q;
    assign ncs_o       = ncs_q;
    assign copi_o      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: CLK_DIV=4 and CLK_DIV=3 instances, a bit-level target model per instance,
// and a queue of expected frames popped at each done pulse.
module tb_spi_controller;

    typedef struct {
        logic        w;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [7:0]  cb;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [1:0]      cmd_valid;
    logic [1:0]      cmd_write;
    logic [1:0][6:0] cmd_addr;
    logic [1:0][7:0] cmd_data;
    logic [1:0]      ready;
    logic [1:0]      done;
    logic [1:0][7:0] rd_data;
    logic [1:0]      sclk;
    logic [1:0]      ncs;
    logic [1:0]      copi;
    logic [1:0]      cipo;
    logic [1:0][7:0] cipo_byte;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // target-side monitor state, written only by the monitor process
    logic [1:0]  ncs_p = 2'b11;
    logic [1:0]  sclk_p = 2'b00;
    int          rises [2] = '{0, 0};
    int          falls [2] = '{0, 0};
    int          lo_len [2] = '{0, 0};
    int          hi_len [2] = '{0, 0};
    int          last_hi [2] = '{0, 0};
    int          last_lo [2] = '{0, 0};
    int          last_rises [2] = '{0, 0};
    int          starts [2] = '{0, 0};
    int          dones [2] = '{0, 0};
    int          b2b [2] = '{0, 0};
    int          acc_cyc [2] = '{0, 0};
    int          done_lat [2] = '{0, 0};
    int          done_lo [2] = '{0, 0};
    int          done_rises [2] = '{0, 0};
    logic [15:0] frame [2] = '{16'h0, 16'h0};
    logic [15:0] last_frame [2] = '{16'h0, 16'h0};
    logic [15:0] done_frame [2] = '{16'h0, 16'h0};
    logic [7:0]  done_rd [2] = '{8'h0, 8'h0};
    logic [7:0]  regs [2][128] = '{default: '{default: 8'h00}};

    logic [7:0]  exp_regs [2][128];
    int          n_done_exp [2];
    exp_t        sbq [$];
    vec_t        vt [4];

    spi_controller #(.CLK_DIV(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(ready[0]),
        .cmd_write_i(cmd_write[0]), .cmd_addr_i(cmd_addr[0]), .cmd_data_i(cmd_data[0]),
        .done_o(done[0]), .rd_data_o(rd_data[0]),
        .sclk_o(sclk[0]), .ncs_o(ncs[0]), .copi_o(copi[0]), .cipo_i(cipo[0])
    );

    spi_controller #(.CLK_DIV(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(ready[1]),
        .cmd_write_i(cmd_write[1]), .cmd_addr_i(cmd_addr[1]), .cmd_data_i(cmd_data[1]),
        .done_o(done[1]), .rd_data_o(rd_data[1]),
        .sclk_o(sclk[1]), .ncs_o(ncs[1]), .copi_o(copi[1]), .cipo_i(cipo[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Target model: shifts copi on sclk rises, commits completed write frames, serves cipo_byte MSB first.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!ncs[g] && ncs_p[g]) begin
                rises[g]   <= 0;
                falls[g]   <= 0;
                lo_len[g]  <= 1;
                last_hi[g] <= hi_len[g];
                starts[g]  <= starts[g] + 1;
            end else if (!ncs[g]) begin
                lo_len[g] <= lo_len[g] + 1;
                if (sclk[g] && !sclk_p[g]) begin
                    frame[g] <= {frame[g][14:0], copi[g]};
                    rises[g] <= rises[g] + 1;
                end
                if (!sclk[g] && sclk_p[g]) falls[g] <= falls[g] + 1;
            end
            if (ncs[g] && !ncs_p[g]) hi_len[g] <= 1;
            else if (ncs[g]) hi_len[g] <= hi_len[g] + 1;
            if (ncs[g] && !ncs_p[g]) begin
                last_lo[g]    <= lo_len[g];
                last_rises[g] <= rises[g];
                last_frame[g] <= frame[g];
                if (rises[g] == 16 && frame[g][15]) regs[g][frame[g][14:8]] <= frame[g][7:0];
            end
            if (done[g]) begin
                dones[g]      <= dones[g] + 1;
                done_lat[g]   <= cyc - acc_cyc[g];
                done_lo[g]    <= last_lo[g];
                done_rises[g] <= last_rises[g];
                done_frame[g] <= last_frame[g];
                done_rd[g]    <= rd_data[g];
            end
            if (cmd_valid[g] && ready[g]) begin
                if (done[g]) b2b[g] <= b2b[g] + 1;
                acc_cyc[g] <= cyc;
            end
            cipo[g]   <= (falls[g] >= 8 && falls[g] <= 15) ? cipo_byte[g][3'(15 - falls[g])] : 1'b0;
            ncs_p[g]  <= ncs[g];
            sclk_p[g] <= sclk[g];
        end
    end

    function automatic int div_of(input bit g);
        return g ? 3 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    task automatic fail_to(input string nm);
        n_chk++;
        $display("FAIL %s: got no event within bound, expected one", nm);
    endtask

    task automatic issue(input bit g, input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [7:0] cb, input logic [15:0] ef, input logic [7:0] er,
                         input bit hold);
        int   t;
        exp_t e;
        @(posedge clk);
        #1;
        cmd_write[g]  = w;
        cmd_addr[g]   = a;
        cmd_data[g]   = d;
        cipo_byte[g]  = cb;
        cmd_valid[g]  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready[g] && t < 2000);
        if (!ready[g]) begin
            fail_to("accept_wait");
            cmd_valid[g] = 1'b0;
            return;
        end
        e.frame = ef;
        e.rd    = er;
        sbq.push_back(e);
        if (!hold) begin
            @(posedge clk);
            #1;
            cmd_valid[g] = 1'b0;
        end
    endtask

    task automatic finish_frame(input bit g);
        exp_t e;
        int   t;
        n_done_exp[g]++;
        t = 0;
        while (dones[g] < n_done_exp[g] && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (dones[g] < n_done_exp[g]) begin
            fail_to("done_wait");
            return;
        end
        if (sbq.size() == 0) begin
            fail_to("scoreboard_entry");
            return;
        end
        e = sbq.pop_front();
        chk("frame_bits", done_frame[g], e.frame);
        chk("sclk_rises", done_rises[g], 16);
        chk("ncs_low_cycles", done_lo[g], 33 * div_of(g));
        chk("done_latency", done_lat[g], 34 * div_of(g) + 1);
        chk("rd_data", done_rd[g], e.rd);
        if (e.frame[15]) exp_regs[g][e.frame[14:8]] = e.frame[7:0];
    endtask

    task automatic check_regs(input bit g);
        int addrs [8] = '{0, 1, 2, 3, 4, 5, 'h55, 'h7F};
        foreach (addrs[i]) chk($sformatf("reg%0d_0x%02h", g, addrs[i]), regs[g][addrs[i]], exp_regs[g][addrs[i]]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, b0;
        vt[0] = '{1'b1, 7'h00, 8'hA5, 8'h00, 16'h80A5, 8'h00};
        vt[1] = '{1'b0, 7'h04, 8'h00, 8'h3C, 16'h0400, 8'h3C};
        vt[2] = '{1'b1, 7'h7F, 8'h5A, 8'hC3, 16'hFF5A, 8'hC3};
        vt[3] = '{1'b0, 7'h55, 8'hFF, 8'h81, 16'h55FF, 8'h81};

        for (int g = 0; g < 2; g++) begin
            n_done_exp[g] = 0;
            for (int a = 0; a < 128; a++) exp_regs[g][a] = 8'h00;
        end
        rst       = 1'b1;
        cmd_valid = '0;
        cmd_write = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cipo_byte = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset_sclk", sclk[g], 1'b0);
            chk("reset_ncs", ncs[g], 1'b1);
            chk("reset_copi", copi[g], 1'b0);
            chk("reset_ready", ready[g], 1'b1);
            chk("reset_done", done[g], 1'b0);
            chk("reset_rd_data", rd_data[g], 8'h00);
        end

        // table of single frames on the CLK_DIV=4 instance
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, vt[i].w, vt[i].a, vt[i].d, vt[i].cb, vt[i].exp_frame, vt[i].exp_rd, 1'b0);
            finish_frame(1'b0);
        end
        check_regs(1'b0);

        // back-to-back: cmd_valid held, second command taken in the done cycle
        b0 = b2b[0];
        issue(1'b0, 1'b1, 7'h04, 8'h80, 8'h5A, 16'h8480, 8'h5A, 1'b1);
        issue(1'b0, 1'b1, 7'h02, 8'hFF, 8'h5A, 16'h82FF, 8'h5A, 1'b0);
        finish_frame(1'b0);
        finish_frame(1'b0);
        chk("b2b_accept_in_done", b2b[0] - b0, 1);
        chk("b2b_ncs_high_gap", last_hi[0], 5);
        check_regs(1'b0);

        // busy rejection
        issue(1'b0, 1'b1, 7'h05, 8'h11, 8'h44, 16'h8511, 8'h44, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        cmd_write[0] = 1'b1;
        cmd_addr[0]  = 7'h01;
        cmd_data[0]  = 8'h55;
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        chk("busy_ready_low", ready[0], 1'b0);
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        finish_frame(1'b0);
        s0 = starts[0];
        repeat (300) @(posedge clk);
        chk("busy_no_extra_frame", starts[0], s0);
        check_regs(1'b0);

        // reset after the 8th rising edge
        issue(1'b0, 1'b1, 7'h01, 8'h77, 8'h00, 16'h8177, 8'h00, 1'b0);
        begin
            int t;
            t = 0;
            do begin
                @(posedge clk);
                t++;
            end while (rises[0] < 8 && t < 2000);
            if (rises[0] < 8) fail_to("eighth_rise_wait");
        end
        d0 = dones[0];
        #1 rst = 1'b1;
        #1;
        chk("midrst_sclk", sclk[0], 1'b0);
        chk("midrst_ncs", ncs[0], 1'b1);
        chk("midrst_copi", copi[0], 1'b0);
        chk("midrst_ready", ready[0], 1'b1);
        chk("midrst_rd_data", rd_data[0], 8'h00);
        void'(sbq.pop_back());
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) @(posedge clk);
        chk("midrst_no_done", dones[0], d0);
        check_regs(1'b0);
        issue(1'b0, 1'b1, 7'h01, 8'h3C, 8'h00, 16'h813C, 8'h00, 1'b0);
        finish_frame(1'b0);
        check_regs(1'b0);

        // CLK_DIV=3 instance
        issue(1'b1, 1'b1, 7'h03, 8'h0F, 8'h96, 16'h830F, 8'h96, 1'b0);
        finish_frame(1'b1);
        chk("div3_pwm_en_hi", regs[1][3], 8'h0F);
        check_regs(1'b1);

        chk("final_out_en_lo", regs[0][0], 8'hA5);
        chk("final_duty", regs[0][4], 8'h80);
        chk("final_pwm_en_lo", regs[0][2], 8'hFF);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

Mode-0 SPI controller that drives `sclk`, `ncs` and `copi` toward the on-chip SPI register peripheral, and toward any future SPI target, from a simple valid/ready command port. Each accepted command becomes one 16-bit frame, sent MSB first:

- bit 15: R/W (1 = write)
- bits 14:8: address
- bits 7:0: data

The controller also samples `cipo` during the data byte, so read-capable targets are supported. It sits in the test/bring-up harness and in any on-chip host that configures the output-enable, PWM-enable and duty-cycle registers.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period. Legal range 3..255; the target's 2-flop synchronizer needs at least 3.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: controller idle; a command is accepted when `cmd_valid && cmd_ready` at a rising `clk` edge.
- `cmd_write` input 1: 1 = write frame, 0 = read frame.
- `cmd_addr` input 7: register address.
- `cmd_data` input 8: write data. Sent as-is on reads.
- `done` output 1: one-cycle pulse at frame completion.
- `rd_data` output 8: byte sampled from `cipo`. Valid from `done` onward; held until the next `done`.
- `sclk` output 1: SPI clock, idles low.
- `ncs` output 1: chip select, active low, idles high.
- `copi` output 1: serial data out.
- `cipo` input 1: serial data in.

## Operation
- The state machine has four states: IDLE, SHIFT, HOLD, GAP.
  - IDLE: `cmd_ready=1`, `ncs=1`, `sclk=0`, `copi=0`. On accept, latch `{cmd_write, cmd_addr, cmd_data}` into a 16-bit shift register, clear the bit counter, and go to SHIFT. Later changes on the command inputs are ignored.
  - SHIFT: `ncs=0`. For each of 16 bits:
    - Low phase of CLK_DIV cycles, with `copi` = current MSB.
    - High phase of CLK_DIV cycles.
    - At the end of the high phase, `sclk` falls and the register shifts left by one in the same cycle.
    - After the 16th high phase, go to HOLD.
  - HOLD: `ncs=0`, `sclk=0` for CLK_DIV cycles, then go to GAP.
  - GAP: `ncs=1` for CLK_DIV cycles, then go to IDLE with `done=1` for that first IDLE cycle.
- `copi` changes only while `sclk` is low. It is stable for CLK_DIV cycles before each rising edge and for CLK_DIV cycles after it.
- `cipo` is sampled in the last `clk` cycle of the high phases for bits 7..0 (frame bits 7:0) and shifted into a capture register MSB first. `rd_data` loads from the capture register when `done` asserts. Capture happens on writes as well.
- `cmd_valid` while busy is not accepted; it is neither queued nor dropped silently, because `cmd_ready=0` during that time.
- Back-to-back: a command may be accepted in the `done` cycle.
- All outputs are registered; no combinational path runs from inputs to `sclk`/`ncs`/`copi`.
- Half-period counter: 8 bits, counts CLK_DIV-1 down to 0. Bit counter: 5 bits, 0..16. No other wrap-around behaviour.

## Timing
- Reset values: `sclk=0`, `ncs=1`, `copi=0`, `cmd_ready=1`, `done=0`, `rd_data=0x00`, state IDLE.
- Reset mid-frame: outputs return to their reset values asynchronously. No `done` is issued, so the target sees an incomplete frame and discards it.
- Accept in cycle 0:
  - `ncs` is low in cycles 1..33·CLK_DIV.
  - Rising edge of bit k (k=0 for bit 15) occurs at cycle 1 + (2k+1)·CLK_DIV.
  - `ncs` is high in the GAP cycles 33·CLK_DIV+1 .. 34·CLK_DIV.
  - `done`, `cmd_ready` and the new `rd_data` appear at cycle 34·CLK_DIV+1.
- CLK_DIV=4: `ncs` low for 132 cycles; `done` at cycle 137.
- Minimum `ncs`-high time between back-to-back frames is CLK_DIV+1 cycles.
- Throughput is one frame per 34·CLK_DIV+1 cycles.

## Test plan
- **Write**: accept write, addr 0x00, data 0xA5, CLK_DIV=4. Required:
  - `copi` at the 16 rising edges reads 0x80A5 MSB first.
  - Exactly 16 `sclk` rising edges.
  - `ncs` low for 132 cycles; `done` at cycle 137.
  - In loopback with the SPI register peripheral, its out-enable[7:0] register = 0xA5.
- **Back-to-back**: hold `cmd_valid` with writes (0x04, 0x80), then (0x02, 0xFF). Required:
  - The second command is accepted in the first `done` cycle.
  - `ncs` is high for exactly 5 cycles between frames.
  - The peripheral duty-cycle register = 0x80 and PWM-enable[7:0] register = 0xFF.
- **Read**: accept read, addr 0x04, with the bench driving `cipo` per bit to return 0x3C. Required:
  - Frame bit 15 = 0.
  - `rd_data`=0x3C at `done`.
  - Peripheral registers unchanged.
- **Busy rejection**: pulse `cmd_valid` (write 0x01, 0x55) mid-frame. Required: `cmd_ready`=0 and no second frame is generated.
- **Reset mid-frame**: assert `rst` after the 8th rising edge. Required:
  - `ncs`=1, `sclk`=0 and `copi`=0 immediately.
  - No `done`; peripheral registers unchanged.
  - After release, a new write completes normally.
- **CLK_DIV=3 build**: write addr 0x03, data 0x0F. Required: `ncs` low for 99 cycles, `done` at cycle 103, and the peripheral PWM-enable[15:8] register = 0x0F.
